delay_arbiter: RTL and testbench
================================

DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter DELAY_INIT, default 4'd8: delay value loaded at reset.
REQ-002 Parameter LOCKOUT_CYCLES, default 16: key-service holdoff after each key-driven commit, range 1..255.
REQ-003 clk  input  1  single clock domain.
REQ-004 reset_n  input  1  reset; synchronous and active-low.
REQ-005 slower  input  1  one-cycle pulse, request delay+1.
REQ-006 faster  input  1  one-cycle pulse, request delay-1.
REQ-007 pause_req  input  1  one-cycle pulse, toggle pause.
REQ-008 avs_address  input  2  Avalon-MM slave word address.
REQ-009 avs_write / avs_read  input  1 each  Avalon-MM write/read strobes.
REQ-010 avs_writedata  input  32  write data.
REQ-011 avs_readdata  output  32  read data, read latency 1.
REQ-012 avs_waitrequest  output  1  stall; high only in state APPLY.
REQ-013 delay  output  4  current delay to the blinker datapath.
REQ-014 pause  output  1  pause level to the blinker datapath.

Function
REQ-015 FSM states IDLE, APPLY, LOCKOUT; APPLY lasts exactly one cycle, then returns to IDLE, or to LOCKOUT if the commit was key-driven.
REQ-016 Register map: addr 0 DELAY RW bits[3:0]; addr 1 CTRL RW bit0 = pause; addr 2 STATUS RO (bit0 slower_pend, bit1 faster_pend, bits[15:8] chg_cnt); addr 3 reads 0, writes ignored; unused bits read 0.
REQ-017 A write is accepted on any cycle with avs_write=1 and avs_waitrequest=0.
REQ-018 An accepted write to addr 0 loads writedata[3:0] into delay on the next edge and enters APPLY; this applies from IDLE or LOCKOUT.
REQ-019 A write to addr 0 accepted in LOCKOUT abandons the LOCKOUT; the FSM goes APPLY -> IDLE.
REQ-020 A write to addr 1 loads pause from writedata[0] next edge without changing FSM state.
REQ-021 A slower or faster pulse in any state sets the matching pending flag; flags are not lost while the FSM is in APPLY or LOCKOUT.
REQ-022 Key service occurs only in IDLE with no accepted addr-0 write that cycle (HPS has priority).
REQ-023 Slower only pending: delay <= min(delay+1, 15), clear flag, enter APPLY.
REQ-024 Faster only pending: delay <= max(delay-1, 0), clear flag, enter APPLY.
REQ-025 Both flags pending at service: clear both, delay unchanged, stay IDLE, no LOCKOUT.
REQ-026 A pulse arriving in the same cycle its flag is cleared is retained (set wins).
REQ-027 At the saturation boundary (slower at 15, faster at 0): delay is unchanged, the flag is cleared, and the FSM still passes through APPLY into LOCKOUT.
REQ-028 LOCKOUT counts LOCKOUT_CYCLES cycles, then returns to IDLE.
REQ-029 chg_cnt (8-bit) increments by 1 on each edge where delay actually changes value, and wraps 255 -> 0.
REQ-030 A pause_req pulse toggles pause on the next edge in any state.
REQ-031 If pause_req and an addr-1 write occur in the same cycle, the write wins.
REQ-032 A read in any cycle returns the addressed register on the next cycle, sampled at the read cycle.
REQ-033 Reads are never stalled except in APPLY.
REQ-034 delay and pause are registered outputs with no combinational path from inputs.

Reset
REQ-035 With reset_n=0 at a clk edge, on that edge: delay=DELAY_INIT, pause=0, both flags=0, chg_cnt=0, state=IDLE, lockout counter=0, avs_readdata=0.
REQ-036 Reset_n=0 overrides all concurrent pulses and writes.
REQ-037 Reset mid-APPLY or mid-LOCKOUT discards the operation; no partial commit occurs.

Verification
REQ-038 Reset, then single slower pulse -> delay 8->9 two edges later, chg_cnt=1, waitrequest high for 1 cycle, LOCKOUT 16 cycles.
REQ-039 Three slower pulses 1 cycle apart -> delay 9 after first service, 10 only after LOCKOUT ends, 11 after the next LOCKOUT; no pulse lost.
REQ-040 slower and faster in the same cycle in IDLE -> delay stays 8, STATUS bits[1:0]=0, chg_cnt=0.
REQ-041 Write 0xF to addr 0 during LOCKOUT, then slower pulse -> delay=15, no change on slower, chg_cnt not incremented by the slower pulse.
REQ-042 Write addr 0 value 0 coincident with a pending faster in IDLE -> HPS commits 0 first; faster then saturates at 0; STATUS read returns chg_cnt consistent with changes.
REQ-043 Assert reset_n=0 in LOCKOUT with a slower flag pending -> next cycle delay=8, STATUS=0, state IDLE.

Source files
------------

// File: rtl/delay_arbiter.sv
// delay_arbiter
//   Arbitrates updates to the blinker delay between two sources: the HPS over
//   an Avalon-MM slave and the slower/faster push-button pulses. HPS writes
//   win. Each key-driven commit is followed by a lockout window during which
//   further key requests wait (they are counted, not dropped).
//
// Ports
//   clk, reset_n        single clock, synchronous active-low reset
//   slower, faster      one-cycle key pulses: request delay +1 / -1
//   pause_req           one-cycle pulse: toggle pause
//   avs_*               Avalon-MM slave, read latency 1, waitrequest in APPLY
//                       addr 0 DELAY[3:0] RW, addr 1 CTRL[0]=pause RW,
//                       addr 2 STATUS RO {chg_cnt[15:8], faster_pend[1], slower_pend[0]},
//                       addr 3 reads 0
//   delay, pause        registered outputs to the blinker datapath
module delay_arbiter #(
    parameter logic [3:0]  DELAY_INIT     = 4'd8,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        slower,
    input  logic        faster,
    input  logic        pause_req,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [3:0]  delay,
    output logic        pause
);
    localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_LOCKOUT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  delay_q, delay_d;
    logic        pause_q, pause_d;
    // Pending requests are counted so a burst of pulses arriving during
    // APPLY/LOCKOUT is serviced one step per lockout window, none merged.
    logic [3:0]  slow_cnt_q, slow_cnt_d;
    logic [3:0]  fast_cnt_q, fast_cnt_d;
    logic [7:0]  chg_cnt_q, chg_cnt_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        key_commit_q, key_commit_d;  // current APPLY came from a key
    logic [31:0] rdata_q, rdata_d;

    logic wr_acc, rd_acc, hps_dly_wr, hps_ctl_wr;
    logic slow_pend, fast_pend, key_svc, key_one, key_both;
    logic unused_ok;

    assign unused_ok  = ^avs_writedata[31:4];

    assign wr_acc     = avs_write & ~avs_waitrequest;
    assign rd_acc     = avs_read & ~avs_waitrequest;
    assign hps_dly_wr = wr_acc & (avs_address == 2'd0);
    assign hps_ctl_wr = wr_acc & (avs_address == 2'd1);
    assign slow_pend  = (slow_cnt_q != 4'd0);
    assign fast_pend  = (fast_cnt_q != 4'd0);
    // Keys are only serviced in IDLE and yield to a same-cycle HPS delay write.
    assign key_svc    = (state_q == S_IDLE) & ~hps_dly_wr & (slow_pend | fast_pend);
    assign key_one    = key_svc & (slow_pend ^ fast_pend);
    assign key_both   = key_svc & slow_pend & fast_pend;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (hps_dly_wr || key_one) state_d = S_APPLY;
            S_APPLY:   state_d = key_commit_q ? S_LOCKOUT : S_IDLE;
            S_LOCKOUT: begin
                // An HPS delay write abandons the lockout.
                if (hps_dly_wr)                   state_d = S_APPLY;
                else if (lock_cnt_q == LOCK_LAST) state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        avs_waitrequest = (state_q == S_APPLY);
    end

    // Datapath next values
    always_comb begin
        delay_d      = delay_q;
        slow_cnt_d   = slow_cnt_q;
        fast_cnt_d   = fast_cnt_q;
        chg_cnt_d    = chg_cnt_q;
        pause_d      = pause_q;
        rdata_d      = rdata_q;
        key_commit_d = key_one;
        lock_cnt_d   = (state_q == S_LOCKOUT) ? lock_cnt_q + 8'd1 : 8'd0;

        if (hps_dly_wr) begin
            delay_d = avs_writedata[3:0];
        end else if (key_one) begin
            // Saturating step; a saturated step still goes through APPLY/LOCKOUT.
            if (slow_pend) begin
                if (delay_q != 4'hF) delay_d = delay_q + 4'd1;
                slow_cnt_d = slow_cnt_q - 4'd1;
            end else begin
                if (delay_q != 4'h0) delay_d = delay_q - 4'd1;
                fast_cnt_d = fast_cnt_q - 4'd1;
            end
        end else if (key_both) begin
            slow_cnt_d = 4'd0;
            fast_cnt_d = 4'd0;
        end

        // A pulse on the same cycle as its clear is kept (set applied last).
        if (slower && slow_cnt_d != 4'hF) slow_cnt_d = slow_cnt_d + 4'd1;
        if (faster && fast_cnt_d != 4'hF) fast_cnt_d = fast_cnt_d + 4'd1;

        if (delay_d != delay_q) chg_cnt_d = chg_cnt_q + 8'd1;

        if (hps_ctl_wr)     pause_d = avs_writedata[0];
        else if (pause_req) pause_d = ~pause_q;

        if (rd_acc) begin
            case (avs_address)
                2'd0:    rdata_d = {28'd0, delay_q};
                2'd1:    rdata_d = {31'd0, pause_q};
                2'd2:    rdata_d = {16'd0, chg_cnt_q, 6'd0, fast_pend, slow_pend};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            delay_q      <= DELAY_INIT;
            pause_q      <= 1'b0;
            slow_cnt_q   <= 4'd0;
            fast_cnt_q   <= 4'd0;
            chg_cnt_q    <= 8'd0;
            lock_cnt_q   <= 8'd0;
            key_commit_q <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            delay_q      <= delay_d;
            pause_q      <= pause_d;
            slow_cnt_q   <= slow_cnt_d;
            fast_cnt_q   <= fast_cnt_d;
            chg_cnt_q    <= chg_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            key_commit_q <= key_commit_d;
            rdata_q      <= rdata_d;
        end
    end

    assign delay        = delay_q;
    assign pause        = pause_q;
    assign avs_readdata = rdata_q;
endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: directed stimulus, cycle-level reference model,
// per-cycle output compare plus hand-computed literal checkpoints.
module tb_delay_arbiter;
    localparam int LOCK = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        slower = 1'b0, faster = 1'b0, pause_req = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_write = 1'b0, avs_read = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [3:0]  delay;
    logic        pause;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    delay_arbiter dut (
        .clk(clk), .reset_n(reset_n), .slower(slower), .faster(faster),
        .pause_req(pause_req), .avs_address(avs_address), .avs_write(avs_write),
        .avs_read(avs_read), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .delay(delay), .pause(pause)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: pending key requests as counts, lockout as cycles left,
    // APPLY as a one-cycle stall flag.
    int          m_delay, m_slow, m_fast, m_chg, m_lock_left;
    bit          m_pause, m_stall, m_lock_after;
    logic [31:0] m_rdata;

    always @(posedge clk) begin
        int nd, ns, nf, nl;
        bit nst, nla;
        logic [31:0] rd;
        if (!reset_n) begin
            m_delay <= 8; m_pause <= 0; m_slow <= 0; m_fast <= 0; m_chg <= 0;
            m_stall <= 0; m_lock_left <= 0; m_lock_after <= 0; m_rdata <= 32'd0;
        end else begin
            nd = m_delay; ns = m_slow; nf = m_fast; nl = m_lock_left;
            nst = 0; nla = m_lock_after; rd = m_rdata;
            if (avs_read && !m_stall)
                case (avs_address)
                    2'd0:    rd = 32'(m_delay);
                    2'd1:    rd = 32'(m_pause);
                    2'd2:    rd = {16'd0, 8'(m_chg), 6'd0, (m_fast != 0), (m_slow != 0)};
                    default: rd = 32'd0;
                endcase
            if (avs_write && !m_stall && avs_address == 2'd0) begin
                nd = int'(avs_writedata[3:0]); nst = 1; nla = 0; nl = 0;
            end else if (m_stall) begin
                nl = m_lock_after ? LOCK : 0;
            end else if (m_lock_left > 0) begin
                nl = m_lock_left - 1;
            end else if (ns > 0 && nf > 0) begin
                ns = 0; nf = 0;
            end else if (ns > 0) begin
                nd = (m_delay < 15) ? m_delay + 1 : 15; ns--; nst = 1; nla = 1;
            end else if (nf > 0) begin
                nd = (m_delay > 0) ? m_delay - 1 : 0; nf--; nst = 1; nla = 1;
            end
            if (slower) ns = (ns < 15) ? ns + 1 : 15;
            if (faster) nf = (nf < 15) ? nf + 1 : 15;
            if (avs_write && !m_stall && avs_address == 2'd1) m_pause <= avs_writedata[0];
            else if (pause_req) m_pause <= !m_pause;
            m_chg <= (nd != m_delay) ? (m_chg + 1) % 256 : m_chg;
            m_delay <= nd; m_slow <= ns; m_fast <= nf; m_lock_left <= nl;
            m_stall <= nst; m_lock_after <= nla; m_rdata <= rd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_delay", 32'(delay), 32'(m_delay));
            chk("model_pause", 32'(pause), 32'(m_pause));
            chk("model_waitrequest", 32'(avs_waitrequest), 32'(m_stall));
            chk("model_readdata", avs_readdata, m_rdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick(1);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick(1);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        // Reset state
        tick(2);
        reset_n = 1'b1;
        cmp_en = 1'b1;
        chk("reset_delay", 32'(delay), 32'd8);
        chk("reset_pause", 32'(pause), 32'd0);
        chk("reset_readdata", avs_readdata, 32'd0);
        chk("reset_waitreq", 32'(avs_waitrequest), 32'd0);

        // Single slower: 8->9 two edges later, 1-cycle stall, 16-cycle lockout
        slower = 1; tick(1); slower = 0;
        chk("slow1_e1_delay", 32'(delay), 32'd8);
        tick(1);
        chk("slow1_e2_delay", 32'(delay), 32'd9);
        chk("slow1_e2_wait", 32'(avs_waitrequest), 32'd1);
        slower = 1; tick(1); slower = 0;        // pulse during APPLY
        chk("slow1_e3_wait", 32'(avs_waitrequest), 32'd0);
        avs_rd(2'd2, rd);
        chk("slow1_status", rd, 32'h0000_0101);
        tick(15);
        chk("lockout_end_delay", 32'(delay), 32'd9);
        tick(1);
        chk("after_lockout_delay", 32'(delay), 32'd10);
        chk("after_lockout_wait", 32'(avs_waitrequest), 32'd1);
        tick(20);
        avs_rd(2'd2, rd);
        chk("slow2_status", rd, 32'h0000_0200);

        // Three slower pulses one cycle apart
        avs_wr(2'd0, 32'd8);
        tick(2);
        slower = 1; tick(1); slower = 0; tick(1);
        slower = 1; tick(1); slower = 0; tick(1);
        slower = 1; tick(1); slower = 0;
        chk("burst_first", 32'(delay), 32'd9);
        tick(14);
        chk("burst_hold9", 32'(delay), 32'd9);
        tick(1);
        chk("burst_second", 32'(delay), 32'd10);
        tick(17);
        chk("burst_hold10", 32'(delay), 32'd10);
        tick(1);
        chk("burst_third", 32'(delay), 32'd11);
        tick(20);

        // Simultaneous slower+faster cancel
        do_reset();
        chk("rst2_delay", 32'(delay), 32'd8);
        slower = 1; faster = 1; tick(1); slower = 0; faster = 0;
        tick(1);
        chk("both_delay", 32'(delay), 32'd8);
        chk("both_wait", 32'(avs_waitrequest), 32'd0);
        avs_rd(2'd2, rd);
        chk("both_status", rd, 32'h0000_0000);

        // HPS write 0xF during lockout, then saturating slower
        slower = 1; tick(1); slower = 0; tick(1);
        chk("d_svc_delay", 32'(delay), 32'd9);
        tick(1);
        avs_wr(2'd0, 32'h0000_000F);
        chk("d_hps_delay", 32'(delay), 32'd15);
        chk("d_hps_wait", 32'(avs_waitrequest), 32'd1);
        tick(1);
        chk("d_abandon_wait", 32'(avs_waitrequest), 32'd0);
        slower = 1; tick(1); slower = 0; tick(1);
        chk("d_sat_delay", 32'(delay), 32'd15);
        chk("d_sat_wait", 32'(avs_waitrequest), 32'd1);
        tick(1);
        avs_rd(2'd2, rd);
        chk("d_status", rd, 32'h0000_0200);
        tick(20);

        // HPS write 0 vs pending faster: HPS first, faster saturates at 0
        faster = 1; tick(1); faster = 0;
        avs_wr(2'd0, 32'd0);
        chk("e_hps_delay", 32'(delay), 32'd0);
        chk("e_hps_wait", 32'(avs_waitrequest), 32'd1);
        tick(1);
        chk("e_idle_wait", 32'(avs_waitrequest), 32'd0);
        tick(1);
        chk("e_sat_wait", 32'(avs_waitrequest), 32'd1);
        chk("e_sat_delay", 32'(delay), 32'd0);
        tick(1);
        avs_rd(2'd2, rd);
        chk("e_status", rd, 32'h0000_0300);

        // Pause toggle, write-wins, register map corners
        pause_req = 1; tick(1); pause_req = 0;
        chk("pause_toggle", 32'(pause), 32'd1);
        pause_req = 1; avs_wr(2'd1, 32'd0); pause_req = 0;
        chk("pause_write_wins", 32'(pause), 32'd0);
        pause_req = 1; tick(1); pause_req = 0;
        avs_rd(2'd1, rd);
        chk("ctrl_read", rd, 32'd1);
        avs_wr(2'd3, 32'hFFFF_FFFF);
        avs_rd(2'd3, rd);
        chk("addr3_read", rd, 32'd0);
        avs_rd(2'd0, rd);
        chk("delay_read", rd, 32'd0);
        avs_wr(2'd1, 32'h0000_0002);
        chk("pause_bit0_only", 32'(pause), 32'd0);

        // Reset during lockout with slower pending, then during APPLY
        tick(20);
        slower = 1; tick(1); slower = 0; tick(1);
        chk("g_svc_delay", 32'(delay), 32'd1);
        tick(1);
        slower = 1; tick(1); slower = 0;
        tick(3);
        do_reset();
        chk("g_rst_delay", 32'(delay), 32'd8);
        chk("g_rst_wait", 32'(avs_waitrequest), 32'd0);
        avs_rd(2'd2, rd);
        chk("g_rst_status", rd, 32'd0);
        slower = 1; tick(1); slower = 0; tick(1);
        chk("g_idle_delay", 32'(delay), 32'd9);
        chk("g_idle_wait", 32'(avs_waitrequest), 32'd1);
        do_reset();
        chk("g_apply_rst_delay", 32'(delay), 32'd8);
        chk("g_apply_rst_wait", 32'(avs_waitrequest), 32'd0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
